// File: rtl/xpb_lut_sched.sv
// xpb_lut_sched: walks the NUM_SEG index segments of one request through a
// shared, registered lookup table bank and sums the returned words.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; in_upper carries NUM_SEG segments
//   lut_en/sel/idx      table address, one segment per ISSUE cycle
//   lut_data            table word for the address of the previous cycle
//   out_valid/out_ready result handshake; out_sum is the full-width sum
//   busy                high whenever a request is in flight
//
// Timing for a request accepted at edge T: issue cycles T+1..T+NUM_SEG,
// DRAIN at T+NUM_SEG+1 (takes the last word), DONE from T+NUM_SEG+2.

// One latched request segment; loaded only on accept.
module xpb_lut_seg #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [IDX_W-1:0] d,
  output logic [IDX_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end
endmodule

module xpb_lut_sched #(
  parameter  int NUM_SEG = 8,
  parameter  int IDX_W   = 5,
  parameter  int DATA_W  = 1024,
  localparam int SEL_W   = $clog2(NUM_SEG),
  localparam int ACC_W   = DATA_W + $clog2(NUM_SEG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SEG*IDX_W-1:0] in_upper,
  output logic                     lut_en,
  output logic [SEL_W-1:0]         lut_sel,
  output logic [IDX_W-1:0]         lut_idx,
  input  logic [DATA_W-1:0]        lut_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                        state_q, state_d;
  logic [SEL_W-1:0]              cnt_q;
  logic [ACC_W-1:0]              acc_q;
  logic [NUM_SEG-1:0][IDX_W-1:0] seg_q;
  // Table bank is one cycle deep: a word is present in the cycle after its
  // issue, so the issue strobe delayed by one cycle gates the adder.
  logic                          take_q;
  logic                          accept;
  logic                          last_issue;

  assign accept     = (state_q == IDLE) && in_valid;
  assign last_issue = (cnt_q == SEL_W'(NUM_SEG - 1));

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    xpb_lut_seg #(.IDX_W(IDX_W)) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .d     (in_upper[k*IDX_W +: IDX_W]),
      .q     (seg_q[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    lut_en    = 1'b0;
    lut_sel   = '0;
    lut_idx   = '0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ISSUE;
      end
      ISSUE: begin
        lut_en  = 1'b1;
        lut_sel = cnt_q;
        lut_idx = seg_q[cnt_q];
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign out_sum = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      take_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      take_q  <= lut_en;
      if (accept) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else begin
        if (state_q == ISSUE && !last_issue) cnt_q <= cnt_q + 1'b1;
        // ACC_W has room for NUM_SEG full-scale words, so no wrap here.
        if (take_q) acc_q <= acc_q + ACC_W'(lut_data);
      end
    end
  end

endmodule

// File: tb/tb_xpb_lut_sched.sv
module tb_xpb_lut_sched;
  localparam int NS = 8;
  localparam int IW = 5;
  localparam int DW = 1024;
  localparam int SW = 3;
  localparam int AW = 1027;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [NS*IW-1:0] in_upper;
  logic             lut_en;
  logic [SW-1:0]    lut_sel;
  logic [IW-1:0]    lut_idx;
  logic [DW-1:0]    lut_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_sum;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;
  int tmode = 0;

  always #5 clk = ~clk;

  xpb_lut_sched #(.NUM_SEG(NS), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_upper(in_upper), .lut_en(lut_en), .lut_sel(lut_sel), .lut_idx(lut_idx),
    .lut_data(lut_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .busy(busy)
  );

  // Table contents: 0 = {sel,idx}, 1 = all ones, 2 = address-dependent pattern.
  function automatic logic [DW-1:0] tbl(int mode, logic [SW-1:0] s, logic [IW-1:0] i);
    logic [DW-1:0] v;
    v = '0;
    case (mode)
      0: v = DW'({s, i});
      1: v = '1;
      default:
        for (int w = 0; w < 32; w++) v[w*32 +: 32] = {s, i, w[7:0], ~{s, i}, 8'h5A};
    endcase
    return v;
  endfunction

  // Expected result: plain sum of the table words addressed by each segment.
  function automatic logic [AW-1:0] model(int mode, logic [NS*IW-1:0] up);
    logic [AW-1:0] sum;
    sum = '0;
    for (int k = 0; k < NS; k++) sum = sum + AW'(tbl(mode, SW'(k), up[k*IW +: IW]));
    return sum;
  endfunction

  // Registered bank; garbage whenever no lookup was issued last cycle.
  always @(posedge clk)
    lut_data <= lut_en ? tbl(tmode, lut_sel, lut_idx) : {32{$urandom}};

  task automatic chk(string name, logic [AW-1:0] obs, logic [AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%0h..%0h exp=%0h..%0h", name, obs[AW-1:960], obs[63:0],
             exp[AW-1:960], exp[63:0]);
    end
  endtask

  // Runs one request from an IDLE negedge. rst_at >= 0 pulses reset during
  // that issue cycle instead of completing; stall = DONE cycles with out_ready low.
  task automatic run_req(string tag, logic [NS*IW-1:0] up, int mode, int stall, int rst_at);
    logic [AW-1:0] exp;
    tmode = mode;
    exp   = model(mode, up);
    chk({tag, ".idle_rdy"}, AW'({in_ready, busy}), AW'(2'b10));
    in_valid  = 1'b1;
    in_upper  = up;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_upper = {$urandom, $urandom};
    for (int k = 0; k < NS; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, ".issue"}, AW'({lut_en, lut_sel, lut_idx, in_ready}),
          AW'({1'b1, SW'(k), up[k*IW +: IW], 1'b0}));
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, ".async_rst"}, AW'({lut_en, lut_sel, lut_idx, out_valid, busy, in_ready}),
            AW'({1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1}));
        chk({tag, ".rst_sum"}, out_sum, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
    end
    @(negedge clk);
    chk({tag, ".drain"}, AW'({lut_en, out_valid, busy, in_ready}), AW'(4'b0010));
    @(negedge clk);
    chk({tag, ".latency"}, AW'(out_valid), AW'(1'b1));
    chk({tag, ".sum"}, out_sum, exp);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_upper = {$urandom, $urandom};
      @(negedge clk);
      chk({tag, ".stall_ctl"}, AW'({out_valid, in_ready, lut_en}), AW'(3'b100));
      chk({tag, ".stall_sum"}, out_sum, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".after_hs"}, AW'({out_valid, in_ready, busy}), AW'(3'b010));
  endtask

  initial begin
    logic [NS*IW-1:0] cur;
    logic [NS*IW-1:0] q[$];
    int  n_acc, n_res, last_acc;
    bit  just_acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_upper = '1;
    @(negedge clk);
    chk("reset_ctl", AW'({lut_en, lut_sel, lut_idx, out_valid, busy, in_ready}),
        AW'({1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1}));
    chk("reset_sum", out_sum, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req("zero", '0, 0, 0, -1);
    chk("zero_model", model(0, '0), AW'(12'h380));
    run_req("ones_idx", {NS{5'h1F}}, 0, 0, -1);
    run_req("full_w", {$urandom, $urandom}, 1, 0, -1);
    run_req("stall", {$urandom, $urandom}, 2, 20, -1);
    run_req("rst", {$urandom, $urandom}, 0, 0, 3);
    run_req("post_rst", {$urandom, $urandom}, 2, 0, -1);
    for (int r = 0; r < 4; r++)
      run_req("rnd", {$urandom, $urandom}, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), -1);

    // Back-to-back: in_valid and out_ready held high.
    tmode     = 2;
    out_ready = 1'b1;
    cur       = {$urandom, $urandom};
    in_upper  = cur;
    n_acc = 0; n_res = 0; last_acc = -1; just_acc = 1'b0;
    for (int c = 0; c < 200 && n_res < 3; c++) begin
      if (just_acc) begin
        cur      = {$urandom, $urandom};
        in_upper = cur;
      end
      in_valid = (n_acc < 3);
      if (out_valid && q.size() > 0) begin
        chk("b2b.sum", out_sum, model(2, q.pop_front()));
        n_res++;
      end
      just_acc = in_ready && in_valid;
      if (just_acc) begin
        if (last_acc >= 0) chk("b2b.gap", AW'(c - last_acc), AW'(11));
        last_acc = c;
        q.push_back(cur);
        n_acc++;
      end
      @(negedge clk);
    end
    chk("b2b.count", AW'(n_res), AW'(3));
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/xpb_lut_sched.md
XPB_LUT_SCHED -- requirements
Module: xpb_lut_sched

Interface
REQ-001 SHALL provide parameter NUM_SEG, default 8, the number of 5-bit upper-word segments per request.
REQ-002 SHALL provide parameter IDX_W, default 5, the lookup index width per segment.
REQ-003 SHALL provide parameter DATA_W, default 1024, the lookup table data width.
REQ-004 SHALL derive SEL_W = clog2(NUM_SEG) and ACC_W = DATA_W + clog2(NUM_SEG); neither is user-overridable.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  request accepted when in_valid and in_ready are both high at a rising edge.
REQ-009 in_upper  input  NUM_SEG*IDX_W  segments; segment k is bits [k*IDX_W +: IDX_W].
REQ-010 lut_en  output  1  lookup issued this cycle.
REQ-011 lut_sel  output  SEL_W  table (segment) select.
REQ-012 lut_idx  output  IDX_W  table index.
REQ-013 lut_data  input  DATA_W  table output, registered by the shared table bank: value for the address presented in cycle c is valid in cycle c+1.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  result consumed when out_valid and out_ready are both high at a rising edge.
REQ-016 out_sum  output  ACC_W  sum of all NUM_SEG lookups.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-019 IDLE: in_ready=1; on accept, latch in_upper, clear the accumulator and segment counter, and go to ISSUE.
REQ-020 ISSUE: assert lut_en=1, lut_sel=cnt and lut_idx=segment[cnt] for cnt = 0..NUM_SEG-1 on consecutive cycles, then go to DRAIN after cnt reaches NUM_SEG-1.
REQ-021 Accumulation: in each cycle following an issue cycle, add lut_data, zero-extended to ACC_W, into the accumulator.
REQ-022 DRAIN: last cycle in which an addition is taken; lut_en=0; go to DONE.
REQ-023 DONE: out_valid=1 and out_sum=accumulator, both held stable until out_ready; on the handshake go to IDLE.
REQ-024 Latency: a request accepted at edge T SHALL give out_valid high from cycle T+NUM_SEG+2, a fixed latency independent of data; no index value is skipped.
REQ-025 Outside ISSUE, lut_en=0, lut_sel=0 and lut_idx=0.
REQ-026 in_ready SHALL be 0 in ISSUE, DRAIN and DONE; in_valid is ignored there and in_upper changes have no effect after accept.
REQ-027 Throughput: at most one request in flight; after a DONE handshake, in_ready returns at the next cycle (IDLE), giving a minimum request spacing of NUM_SEG+3 cycles.
REQ-028 Arithmetic: ACC_W SHALL hold NUM_SEG*(2^DATA_W-1) without overflow; no modular reduction is performed here.
REQ-029 lut_data SHALL be sampled only in the cycle following an issue cycle; values in other cycles have no effect.
REQ-030 The stalled-output case, out_ready low indefinitely, SHALL hold DONE with no state or output change.

Reset
REQ-031 While rst_n=0, regardless of state: state=IDLE, cnt=0, accumulator=0, latched segments=0, out_valid=0, out_sum=0, lut_en=0, lut_sel=0, lut_idx=0, busy=0, in_ready=1.
REQ-032 Reset asserted mid-ISSUE or mid-DONE SHALL discard the request with no output handshake; operation resumes from IDLE on the first edge after release.

Verification (NUM_SEG=8, DATA_W=1024; behavioural table returning {sel,idx} zero-extended unless stated)
REQ-033 in_upper all zero, accept at T -> lut_sel steps 0..7 at T+1..T+8, out_valid rises at T+10, out_sum = 0+32+...+224 = 0x380.
REQ-034 All segments 5'h1F -> out_sum = 0x478; lut_idx = 0x1F in all 8 issue cycles.
REQ-035 Table returns 2^1024-1 for every address -> out_sum = 2^1027-8, full ACC_W of 1027 bits exercised.
REQ-036 out_ready held low 20 cycles in DONE, with in_valid high and in_upper toggling -> out_sum and out_valid stable, in_ready=0; out_ready high -> in_ready=1 one cycle later.
REQ-037 rst_n pulsed low at the 4th ISSUE cycle -> all outputs at reset values immediately (asynchronously); a new request after release gives the correct sum with latency 10.
REQ-038 Back-to-back requests with out_ready tied high -> accepts separated by exactly 11 cycles; each sum matches its own in_upper.
